// File: rtl/gemm_core_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// gemm_core_ctrl_pkg
// Shared definitions for the GEMM core sequencer: FSM state encoding,
// default loop bounds and the counter-width helper used to size the k/ti
// index ports.
// ---------------------------------------------------------------------------
package gemm_core_ctrl_pkg;

   // Sequencer states. WAIT holds a tile until the output drain is free,
   // ACC runs the reduction steps, FIN reports the end of a batch.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACC  = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam int K_LEN_DEF  = 16;   // reduction steps per tile
   localparam int N_TILE_DEF = 4;    // output tiles per batch

   // Bits needed to index 0..n-1. A count of one still gets a single bit so
   // that no port collapses to zero width.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gemm_core_ctrl_loop1.sv
// ---------------------------------------------------------------------------
// gemm_core_ctrl_loop1
// Single-level modulo loop counter: counts 0..N-1 on each enabled cycle and
// wraps back to 0. Used for the k step index and the tile index.
//
// Ports
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   clr   : synchronous clear (same effect as reset)
//   en    : advance the count by one
//   cnt   : current index, never exceeds N-1
//   last  : cnt is at N-1 (the next enabled cycle wraps)
// ---------------------------------------------------------------------------
module gemm_core_ctrl_loop1
   import gemm_core_ctrl_pkg::*;
#(
   parameter int N = 4,
   parameter int W = cnt_width(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         last
);

   localparam logic [W-1:0] MAX = W'(N - 1);

   assign last = (cnt == MAX);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= last ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/gemm_core_ctrl.sv
// ---------------------------------------------------------------------------
// gemm_core_ctrl
// Sequencer for a GEMM MAC array. Each batch runs N_TILE output tiles; each
// tile issues K_LEN accumulate steps (exec), one per cycle, with k_init on
// the first step and k_fin on the last. A tile only starts while the output
// drain is idle. One extra batch request can be queued (pend); a further
// request while one is queued is dropped and flagged in err_ovf.
//
// Ports
//   clk, reset : clock and synchronous active-high reset
//   run        : enable; low clears everything except err_ovf
//   s_init     : one-cycle pulse, a source batch is ready
//   out_busy   : output drain busy, holds a tile in WAIT
//   exec       : accumulate enable, one k step per cycle
//   k_init     : first step of a tile (clear accumulators)
//   k_fin      : last step of a tile
//   ia         : source buffer address, k during exec, 0 otherwise
//   ti         : current tile index (weight bank select)
//   s_fin      : one-cycle pulse, all tiles of the batch issued
//   busy       : not IDLE, or a batch is pending
//   err_ovf    : sticky, a request arrived while one was already pending
// ---------------------------------------------------------------------------
module gemm_core_ctrl
   import gemm_core_ctrl_pkg::*;
#(
   parameter int K_LEN  = K_LEN_DEF,
   parameter int N_TILE = N_TILE_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         run,
   input  logic                         s_init,
   input  logic                         out_busy,
   output logic                         exec,
   output logic                         k_init,
   output logic                         k_fin,
   output logic [cnt_width(K_LEN)-1:0]  ia,
   output logic [cnt_width(N_TILE)-1:0] ti,
   output logic                         s_fin,
   output logic                         busy,
   output logic                         err_ovf
);

   localparam int KW = cnt_width(K_LEN);
   localparam int TW = cnt_width(N_TILE);

   state_t        state;
   logic          pend;
   logic          gap;      // first WAIT cycle after a tile: forced bubble
   logic [KW-1:0] k;
   logic          k_last;
   logic          ti_last;

   // The first step of a tile is issued from WAIT itself, so a ready drain
   // costs no extra cycle. out_busy is only looked at here, never in ACC,
   // so a drain that turns busy mid-tile cannot stall the reduction.
   assign exec   = (state == ACC) || ((state == WAIT) && !out_busy && !gap);
   assign k_init = exec && (k == '0);
   assign k_fin  = exec && k_last;
   assign ia     = exec ? k : '0;
   assign s_fin  = (state == FIN);
   assign busy   = (state != IDLE) || pend;

   // k advances on every step; ti advances on the last step of each tile
   // and wraps to 0 after the final tile.
   gemm_core_ctrl_loop1 #(.N(K_LEN), .W(KW)) u_k_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (!run),
      .en    (exec),
      .cnt   (k),
      .last  (k_last)
   );

   gemm_core_ctrl_loop1 #(.N(N_TILE), .W(TW)) u_ti_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (!run),
      .en    (exec && k_last),
      .cnt   (ti),
      .last  (ti_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pend    <= 1'b0;
         gap     <= 1'b0;
         err_ovf <= 1'b0;
      end else if (!run) begin
         state <= IDLE;
         pend  <= 1'b0;
         gap   <= 1'b0;
      end else begin
         gap <= 1'b0;

         // A request outside IDLE is queued; with one already queued it is
         // dropped and flagged. The IDLE/FIN arms below override pend when
         // they consume the queued request.
         if (s_init && pend) begin
            err_ovf <= 1'b1;
         end else if (s_init && (state != IDLE)) begin
            pend <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (s_init || pend) begin
                  state <= WAIT;
                  pend  <= 1'b0;
               end
            end
            WAIT: begin
               if (exec) state <= ACC;
            end
            ACC: begin
               if (k_last) begin
                  if (ti_last) begin
                     state <= FIN;
                  end else begin
                     state <= WAIT;
                     gap   <= 1'b1;
                  end
               end
            end
            FIN: begin
               // A request arriving in this very cycle chains straight into
               // the next batch, same as one that was already queued.
               if (pend || s_init) begin
                  state <= WAIT;
                  pend  <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gemm_core_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gemm_core_ctrl
// Bench for gemm_core_ctrl. dut_a uses the default geometry (16 steps,
// 4 tiles), dut_b the smallest one (2 steps, 1 tile). Expected k_init /
// k_fin / s_fin events (cycle and tile index) are queued when stimulus is
// driven and matched as the DUTs produce them; each test task adds its own
// direct checks on top.
// ---------------------------------------------------------------------------
module tb_gemm_core_ctrl;

   typedef enum int {EV_KINIT = 0, EV_KFIN = 1, EV_SFIN = 2} ev_kind_t;
   typedef struct {
      int       cyc;
      ev_kind_t kind;
      int       ti;
   } ev_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic run = 1'b1;
   logic s_init = 1'b0;
   logic s_init_b = 1'b0;
   logic out_busy = 1'b0;

   logic       exec_a, k_init_a, k_fin_a, s_fin_a, busy_a, err_a;
   logic [3:0] ia_a;
   logic [1:0] ti_a;
   logic       exec_b, k_init_b, k_fin_b, s_fin_b, busy_b, err_b;
   logic [0:0] ia_b;
   logic [0:0] ti_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   ev_t exp_a[$];
   ev_t exp_b[$];
   ev_t ev_a, ev_b;
   logic hit_a, hit_b;
   int exec_cnt_a = 0, ia_bad_a = 0, kpos_a = 0;
   int exec_cnt_b = 0, ia_bad_b = 0, kpos_b = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   gemm_core_ctrl dut_a (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .s_init   (s_init),
      .out_busy (out_busy),
      .exec     (exec_a),
      .k_init   (k_init_a),
      .k_fin    (k_fin_a),
      .ia       (ia_a),
      .ti       (ti_a),
      .s_fin    (s_fin_a),
      .busy     (busy_a),
      .err_ovf  (err_a)
   );

   gemm_core_ctrl #(.K_LEN(2), .N_TILE(1)) dut_b (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .s_init   (s_init_b),
      .out_busy (out_busy),
      .exec     (exec_b),
      .k_init   (k_init_b),
      .k_fin    (k_fin_b),
      .ia       (ia_b),
      .ti       (ti_b),
      .s_fin    (s_fin_b),
      .busy     (busy_b),
      .err_ovf  (err_b)
   );

   // Monitor / scoreboard for dut_a, sampled mid-cycle.
   always @(negedge clk) begin
      if (exec_a === 1'b1) begin
         exec_cnt_a++;
         kpos_a = (k_init_a === 1'b1) ? 0 : kpos_a + 1;
         if (int'(ia_a) != kpos_a) ia_bad_a++;
      end else if (ia_a !== 4'd0) begin
         ia_bad_a++;
      end
      for (int e = 0; e < 3; e++) begin
         case (e)
            0:       hit_a = k_init_a;
            1:       hit_a = k_fin_a;
            default: hit_a = s_fin_a;
         endcase
         if (hit_a === 1'b1) begin
            checks++;
            if (exp_a.size() == 0) begin
               errors++;
               $display("FAIL sb_a: unexpected event kind=%0d ti=%0d at cycle %0d, expected none", e, ti_a, cyc);
            end else begin
               ev_a = exp_a.pop_front();
               if (ev_a.cyc != cyc || int'(ev_a.kind) != e || ev_a.ti != int'(ti_a)) begin
                  errors++;
                  $display("FAIL sb_a: got kind=%0d cyc=%0d ti=%0d, expected kind=%0d cyc=%0d ti=%0d",
                           e, cyc, ti_a, int'(ev_a.kind), ev_a.cyc, ev_a.ti);
               end
            end
         end
      end
   end

   // Monitor / scoreboard for dut_b.
   always @(negedge clk) begin
      if (exec_b === 1'b1) begin
         exec_cnt_b++;
         kpos_b = (k_init_b === 1'b1) ? 0 : kpos_b + 1;
         if (int'(ia_b) != kpos_b) ia_bad_b++;
      end else if (ia_b !== 1'b0) begin
         ia_bad_b++;
      end
      for (int e = 0; e < 3; e++) begin
         case (e)
            0:       hit_b = k_init_b;
            1:       hit_b = k_fin_b;
            default: hit_b = s_fin_b;
         endcase
         if (hit_b === 1'b1) begin
            checks++;
            if (exp_b.size() == 0) begin
               errors++;
               $display("FAIL sb_b: unexpected event kind=%0d ti=%0d at cycle %0d, expected none", e, ti_b, cyc);
            end else begin
               ev_b = exp_b.pop_front();
               if (ev_b.cyc != cyc || int'(ev_b.kind) != e || ev_b.ti != int'(ti_b)) begin
                  errors++;
                  $display("FAIL sb_b: got kind=%0d cyc=%0d ti=%0d, expected kind=%0d cyc=%0d ti=%0d",
                           e, cyc, ti_b, int'(ev_b.kind), ev_b.cyc, ev_b.ti);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic push_a(input int c, input ev_kind_t k, input int t);
      ev_t ev;
      ev.cyc = c; ev.kind = k; ev.ti = t;
      exp_a.push_back(ev);
   endtask

   task automatic push_b(input int c, input ev_kind_t k, input int t);
      ev_t ev;
      ev.cyc = c; ev.kind = k; ev.ti = t;
      exp_b.push_back(ev);
   endtask

   // Default geometry, drain idle, request sampled in cycle t: tile i runs
   // cycles t+1+17i .. t+16+17i, s_fin at t+68 with ti already wrapped.
   task automatic push_batch_a(input int t);
      for (int i = 0; i < 4; i++) begin
         push_a(t + 1 + 17 * i, EV_KINIT, i);
         push_a(t + 16 + 17 * i, EV_KFIN, i);
      end
      push_a(t + 68, EV_SFIN, 0);
   endtask

   task automatic test_reset();
      reset = 1'b1; run = 1'b1; s_init = 1'b0; s_init_b = 1'b0; out_busy = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if ({exec_a, k_init_a, k_fin_a, s_fin_a, busy_a, err_a, ia_a, ti_a} !== 12'd0) begin
         errors++;
         $display("FAIL reset_a: outputs=%b expected all zero", {exec_a, k_init_a, k_fin_a, s_fin_a, busy_a, err_a, ia_a, ti_a});
      end
      checks++;
      if ({exec_b, k_init_b, k_fin_b, s_fin_b, busy_b, err_b, ia_b, ti_b} !== 8'd0) begin
         errors++;
         $display("FAIL reset_b: outputs=%b expected all zero", {exec_b, k_init_b, k_fin_b, s_fin_b, busy_b, err_b, ia_b, ti_b});
      end
      reset = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if ({exec_a, busy_a, err_a, ia_a, ti_a} !== 9'd0 || {exec_b, busy_b, err_b} !== 3'd0) begin
         errors++;
         $display("FAIL idle_after_reset: a=%b b=%b expected zero", {exec_a, busy_a, err_a, ia_a, ti_a}, {exec_b, busy_b, err_b});
      end
   endtask

   task automatic test_single_batch();
      int t0;
      exec_cnt_a = 0; ia_bad_a = 0;
      tick();
      s_init = 1'b1; t0 = cyc; push_batch_a(t0);
      tick();
      s_init = 1'b0;
      @(negedge clk);
      checks++;
      if (exec_a !== 1'b1 || busy_a !== 1'b1) begin
         errors++;
         $display("FAIL single_latency: exec=%b busy=%b expected 1 1 one cycle after s_init", exec_a, busy_a);
      end
      run_until(t0 + 70);
      @(negedge clk);
      checks++;
      if (exp_a.size() != 0 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL single_done: pending events=%0d busy=%b expected 0 0", exp_a.size(), busy_a);
      end
      checks++;
      if (exec_cnt_a != 64 || ia_bad_a != 0) begin
         errors++;
         $display("FAIL single_exec: exec cycles=%0d ia errors=%0d expected 64 0", exec_cnt_a, ia_bad_a);
      end
   endtask

   task automatic test_out_busy();
      int t0;
      exec_cnt_a = 0; ia_bad_a = 0;
      tick();
      s_init = 1'b1; t0 = cyc;
      push_a(t0 + 1, EV_KINIT, 0);
      push_a(t0 + 16, EV_KFIN, 0);
      // Drain busy for 5 cycles after the first k_fin: tile 1 starts at t0+22.
      for (int i = 1; i < 4; i++) begin
         push_a(t0 + 22 + 17 * (i - 1), EV_KINIT, i);
         push_a(t0 + 37 + 17 * (i - 1), EV_KFIN, i);
      end
      push_a(t0 + 72, EV_SFIN, 0);
      while (cyc < t0 + 75) begin
         tick();
         s_init = 1'b0;
         // Second busy window lies inside tile 1's reduction and must not stall it.
         out_busy = ((cyc >= t0 + 17) && (cyc <= t0 + 21)) || ((cyc >= t0 + 25) && (cyc <= t0 + 30));
         if (cyc == t0 + 21 || cyc == t0 + 22) begin
            @(negedge clk);
            checks++;
            if (exec_a !== (cyc == t0 + 22) || ti_a !== 2'd1 || ia_a !== 4'd0) begin
               errors++;
               $display("FAIL busy_hold cyc+%0d: exec=%b ti=%0d ia=%0d expected exec=%0b ti=1 ia=0",
                        cyc - t0, exec_a, ti_a, ia_a, (cyc == t0 + 22));
            end
         end
      end
      out_busy = 1'b0;
      @(negedge clk);
      checks++;
      if (exp_a.size() != 0 || busy_a !== 1'b0 || exec_cnt_a != 64 || ia_bad_a != 0) begin
         errors++;
         $display("FAIL busy_done: pending=%0d busy=%b exec cycles=%0d ia errors=%0d expected 0 0 64 0",
                  exp_a.size(), busy_a, exec_cnt_a, ia_bad_a);
      end
   endtask

   // Second request queued while a batch runs (issue cycle d after start),
   // or arriving exactly in the FIN cycle when d = 68.
   task automatic test_back_to_back(input int d, input string name);
      int t0;
      tick();
      s_init = 1'b1; t0 = cyc; push_batch_a(t0);
      while (cyc < t0 + 140) begin
         tick();
         s_init = (cyc == t0 + d);
         if (cyc == t0 + d) push_batch_a(t0 + 68);
         if (cyc == t0 + 69) begin
            @(negedge clk);
            checks++;
            if (exec_a !== 1'b1 || busy_a !== 1'b1 || ti_a !== 2'd0) begin
               errors++;
               $display("FAIL %s_chain: exec=%b busy=%b ti=%0d expected 1 1 0 right after s_fin", name, exec_a, busy_a, ti_a);
            end
         end
      end
      s_init = 1'b0;
      @(negedge clk);
      checks++;
      if (exp_a.size() != 0 || busy_a !== 1'b0 || err_a !== 1'b0) begin
         errors++;
         $display("FAIL %s_done: pending=%0d busy=%b err_ovf=%b expected 0 0 0", name, exp_a.size(), busy_a, err_a);
      end
   endtask

   task automatic test_overflow();
      int t0;
      tick();
      s_init = 1'b1; t0 = cyc; push_batch_a(t0);
      while (cyc < t0 + 140) begin
         tick();
         s_init = (cyc == t0 + 20) || (cyc == t0 + 30);
         if (cyc == t0 + 20) push_batch_a(t0 + 68);
         if (cyc == t0 + 29 || cyc == t0 + 31) begin
            @(negedge clk);
            checks++;
            if (err_a !== (cyc == t0 + 31)) begin
               errors++;
               $display("FAIL ovf_flag cyc+%0d: err_ovf=%b expected %0b", cyc - t0, err_a, (cyc == t0 + 31));
            end
         end
      end
      s_init = 1'b0;
      @(negedge clk);
      checks++;
      if (exp_a.size() != 0 || busy_a !== 1'b0 || err_a !== 1'b1) begin
         errors++;
         $display("FAIL ovf_done: pending=%0d busy=%b err_ovf=%b expected 0 0 1", exp_a.size(), busy_a, err_a);
      end
      run = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if (err_a !== 1'b1 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL ovf_sticky_run: err_ovf=%b busy=%b expected 1 0 with run low", err_a, busy_a);
      end
      run = 1'b1;
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (err_a !== 1'b0) begin
         errors++;
         $display("FAIL ovf_reset: err_ovf=%b expected 0 after reset", err_a);
      end
   endtask

   task automatic test_run_drop();
      int t0, t2;
      exec_cnt_a = 0; ia_bad_a = 0;
      tick();
      s_init = 1'b1; t0 = cyc;
      push_a(t0 + 1, EV_KINIT, 0);
      push_a(t0 + 16, EV_KFIN, 0);
      push_a(t0 + 18, EV_KINIT, 1);
      tick();
      s_init = 1'b0;
      run_until(t0 + 25);
      @(negedge clk);
      checks++;
      if (exec_a !== 1'b1 || ia_a !== 4'd7 || ti_a !== 2'd1) begin
         errors++;
         $display("FAIL drop_pre: exec=%b ia=%0d ti=%0d expected 1 7 1", exec_a, ia_a, ti_a);
      end
      run = 1'b0;
      tick();
      @(negedge clk);
      checks++;
      if ({exec_a, k_fin_a, s_fin_a, busy_a} !== 4'd0 || ia_a !== 4'd0 || ti_a !== 2'd0) begin
         errors++;
         $display("FAIL drop_post: exec/k_fin/s_fin/busy=%b ia=%0d ti=%0d expected 0000 0 0",
                  {exec_a, k_fin_a, s_fin_a, busy_a}, ia_a, ti_a);
      end
      run_until(t0 + 30);
      run = 1'b1;
      repeat (2) tick();
      s_init = 1'b1; t2 = cyc; push_batch_a(t2);
      tick();
      s_init = 1'b0;
      run_until(t2 + 70);
      @(negedge clk);
      checks++;
      if (exp_a.size() != 0 || busy_a !== 1'b0 || ia_bad_a != 0 || exec_cnt_a != 8 + 16 + 64) begin
         errors++;
         $display("FAIL drop_restart: pending=%0d busy=%b ia errors=%0d exec cycles=%0d expected 0 0 0 88",
                  exp_a.size(), busy_a, ia_bad_a, exec_cnt_a);
      end
   endtask

   task automatic test_small();
      int t1;
      exec_cnt_b = 0; ia_bad_b = 0;
      tick();
      s_init_b = 1'b1; t1 = cyc;
      push_b(t1 + 1, EV_KINIT, 0);
      push_b(t1 + 2, EV_KFIN, 0);
      push_b(t1 + 3, EV_SFIN, 0);
      tick();
      // Second request lands while the first is in WAIT: queued, then run
      // straight out of FIN.
      push_b(t1 + 4, EV_KINIT, 0);
      push_b(t1 + 5, EV_KFIN, 0);
      push_b(t1 + 6, EV_SFIN, 0);
      tick();
      s_init_b = 1'b0;
      run_until(t1 + 9);
      @(negedge clk);
      checks++;
      if (exp_b.size() != 0 || busy_b !== 1'b0 || exec_cnt_b != 4 || ia_bad_b != 0 || err_b !== 1'b0) begin
         errors++;
         $display("FAIL small_done: pending=%0d busy=%b exec cycles=%0d ia errors=%0d err_ovf=%b expected 0 0 4 0 0",
                  exp_b.size(), busy_b, exec_cnt_b, ia_bad_b, err_b);
      end
   endtask

   initial begin
      test_reset();
      test_single_batch();
      test_out_busy();
      test_back_to_back(40, "b2b");
      test_back_to_back(68, "fin_cycle");
      test_overflow();
      test_run_drop();
      test_small();
      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
      $fatal(1);
   end

endmodule

// File: doc/gemm_core_ctrl.md
GEMM_CORE_CTRL -- requirements
Module: gemm_core_ctrl

Interface
REQ-001 Parameter K_LEN, default 16, reduction steps per tile (power of two, 2..256).
REQ-002 Parameter N_TILE, default 4, output tiles per batch (power of two, 1..16).
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 run  in  1  enable; low acts as synchronous clear of all state except err_ovf.
REQ-006 s_init  in  1  one-cycle pulse: a source batch is loaded and ready.
REQ-007 out_busy  in  1  output drain busy; a new tile shall not start while high.
REQ-008 exec  out  1  accumulate enable to the MAC array, one k step per cycle.
REQ-009 k_init  out  1  pulse with the first exec of a tile (clear accumulators).
REQ-010 k_fin  out  1  pulse with the last exec of a tile.
REQ-011 ia  out  log2(K_LEN)  source buffer read address, equal to k index.
REQ-012 ti  out  log2(N_TILE)  current tile index, selects the weight bank.
REQ-013 s_fin  out  1  one-cycle pulse: all tiles of the batch issued.
REQ-014 busy  out  1  high in any state other than IDLE, or while pend is set.
REQ-015 err_ovf  out  1  sticky: s_init arrived while a batch was already pending.

Function
REQ-016 FSM states: IDLE, WAIT, ACC, FIN.
REQ-017 IDLE: on s_init (or pend set) go to WAIT; consume pend.
REQ-018 WAIT: while out_busy is high, hold; when out_busy is low, go to ACC with k=0; exec and k_init shall be asserted in that same cycle.
REQ-019 ACC: exec=1 every cycle; k increments by 1; k_init only at k=0, k_fin only at k=K_LEN-1.
REQ-020 At k=K_LEN-1 with ti<N_TILE-1: ti increments, next state WAIT (one-cycle gap minimum between tiles).
REQ-021 At k=K_LEN-1 with ti=N_TILE-1: next state FIN; ti wraps to 0.
REQ-022 FIN: s_fin=1 for exactly one cycle; next state WAIT if pend set (pend cleared), else IDLE.
REQ-023 k and ti are modulo counters; they shall never exceed K_LEN-1 or N_TILE-1.
REQ-024 K_LEN=2 shall produce k_init and k_fin on consecutive cycles; ia holds k during exec, 0 otherwise.
REQ-025 s_init while state is not IDLE: set pend; if pend already set, set err_ovf and drop the pulse.
REQ-026 s_init in IDLE with pend clear: go to WAIT directly; pend stays clear.
REQ-027 s_init in the FIN cycle is treated as pending and starts the next batch without passing IDLE.
REQ-028 out_busy rising during ACC shall not stall the tile in progress; it is sampled only in WAIT.
REQ-029 Minimum s_init-to-first-exec latency: 1 cycle (s_init at t, WAIT at t+1, exec at t+1 if out_busy low).
REQ-030 Outputs exec, k_init, k_fin, s_fin are decoded from registered state/counters; no combinational path from s_init to any output.

Reset
REQ-031 On reset: state IDLE, k=0, ti=0, pend=0, err_ovf=0; all outputs 0.
REQ-032 run low: same as reset except err_ovf retained; reset mid-batch aborts without emitting k_fin or s_fin.

Structure
REQ-033 FSM state enum and default K_LEN/N_TILE constants belong in the shared gemm package.
REQ-034 k and ti counters shall use the existing loop1 counter sub-module (two instances, k driving ti enable).

Verification
REQ-035 Single batch, out_busy=0, defaults: s_init at t0 -> exec t0+1..t0+16, k_init t0+1, k_fin t0+16, four tiles with 1-cycle gaps, s_fin at t0+68.
REQ-036 out_busy held high 5 cycles after first k_fin -> tile 1 exec starts the cycle after out_busy falls; ti=1, ia restarts at 0.
REQ-037 Second s_init during tile 2 -> pend=1; after s_fin next batch enters WAIT directly, no IDLE cycle; err_ovf=0.
REQ-038 Three s_init pulses during one batch -> err_ovf=1 and stays 1 after run drops; only two batches execute.
REQ-039 run dropped at k=7 of tile 1 -> next cycle state IDLE, exec=0, no k_fin/s_fin; new s_init restarts at ti=0,k=0.
REQ-040 K_LEN=2, N_TILE=1: s_init -> exec 2 cycles, k_init/k_fin adjacent, s_fin next cycle.
